// File: rtl/cla_serial_add_sequencer.sv
// cla_serial_add_sequencer
// Serial wide adder that reuses one 4-bit carry-lookahead slice.
// The slice processes one nibble per clock, and a registered carry links
// consecutive nibbles. Operands arrive and results leave through
// valid/ready handshakes.
// Optional feature: define CLA_SEQ_EARLY_EXIT_EN to finish as soon as the
// remaining operand nibbles are all zero and no carry is pending.
//
// state | meaning
// IDLE  | waiting for operands, ready_o=1
// RUN   | one nibble added per clock, carry held in r_carry
// DONE  | result presented on sum_o, waiting for ready_i

module cla_serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] number_1_i,
  input  logic [WIDTH-1:0] number_2_i,
  input  logic             carry_i_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   sum_o,
  output logic             busy_o
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_sum;

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;
  logic       w_cout;
  logic [3:0] w_sum_nib;
  logic       w_last;
  logic       w_early;

  assign w_a_nib = r_a[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_cnt, 2'b00} +: 4];
  assign w_last  = (r_cnt == LAST);

  // 4-bit carry-lookahead slice: every carry is computed directly from
  // generate/propagate terms, with no ripple inside the nibble.
  always_comb begin
    w_g = w_a_nib & w_b_nib;
    w_p = w_a_nib ^ w_b_nib;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & r_carry);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & r_carry);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & r_carry);
    w_sum_nib = w_p ^ w_c;
  end

`ifdef CLA_SEQ_EARLY_EXIT_EN
  logic w_rest_zero;

  // Exit early when every operand nibble above the current one is zero and
  // this nibble produced no carry, so the remaining sum bits stay 0.
  always_comb begin
    w_rest_zero = 1'b1;
    for (int j = 0; j < N; j++) begin
      if ((j > int'(r_cnt)) && ((r_a[4*j +: 4] | r_b[4*j +: 4]) != 4'h0)) begin
        w_rest_zero = 1'b0;
      end
    end
    w_early = w_rest_zero && !w_cout && !w_last;
  end
`else
  assign w_early = 1'b0;
`endif

  // Sequencing FSM with the operand, carry, counter and sum registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_a     <= number_1_i;
            r_b     <= number_2_i;
            r_carry <= carry_i_i;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[{r_cnt, 2'b00} +: 4] <= w_sum_nib;
          r_carry <= w_cout;
          if (w_last) begin
            r_sum[WIDTH] <= w_cout;
            r_state      <= S_DONE;
          end else if (w_early) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o = (r_state == S_IDLE);
  assign valid_o = (r_state == S_DONE);
  assign busy_o  = (r_state == S_RUN) || (r_state == S_DONE);
  assign sum_o   = r_sum;

endmodule

// File: tb/tb_cla_serial_add_sequencer.sv
// Directed testbench for cla_serial_add_sequencer (16-bit and 32-bit instances).
module tb_cla_serial_add_sequencer;

  logic clk;
  logic rst;

  logic        v16, ro16, cin16, vo16, rdy16, bo16;
  logic [15:0] a16, b16;
  logic [16:0] s16;

  logic        v32, ro32, cin32, vo32, rdy32, bo32;
  logic [31:0] a32, b32;
  logic [32:0] s32;

  int tests_run;
  int tests_failed;

  cla_serial_add_sequencer #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .valid_i(v16), .ready_o(ro16),
    .number_1_i(a16), .number_2_i(b16), .carry_i_i(cin16),
    .valid_o(vo16), .ready_i(rdy16), .sum_o(s16), .busy_o(bo16)
  );

  cla_serial_add_sequencer #(.WIDTH(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(ro32),
    .number_1_i(a32), .number_2_i(b32), .carry_i_i(cin32),
    .valid_o(vo32), .ready_i(rdy32), .sum_o(s32), .busy_o(bo32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one 16-bit operand pair and wait for valid_o; lat counts clocks
  // from the accept edge, ok drops if ready_o/busy_o misbehave while running.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output int lat, output logic ok);
    @(negedge clk);
    a16 = a; b16 = b; cin16 = cin; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    ok  = 1'b1;
    while (vo16 !== 1'b1 && lat < 50) begin
      if (ro16 !== 1'b0 || bo16 !== 1'b1) ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume16();
    @(negedge clk);
    rdy16 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (ro16 !== 1'b1 || vo16 !== 1'b0 || bo16 !== 1'b0 || s16 !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset16: ready=%b valid=%b busy=%b sum=%h, want 1 0 0 00000", ro16, vo16, bo16, s16);
    end
    tests_run++;
    if (ro32 !== 1'b1 || vo32 !== 1'b0 || bo32 !== 1'b0 || s32 !== 33'h0) begin
      tests_failed++;
      $display("FAIL reset32: ready=%b valid=%b busy=%b sum=%h, want 1 0 0 0", ro32, vo32, bo32, s32);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_ripple();
    int lat; logic ok;
    run16(16'hFFFF, 16'h0001, 1'b0, lat, ok);
    tests_run++;
    if (s16 !== 17'h10000) begin
      tests_failed++;
      $display("FAIL ripple_sum: got %h want 10000", s16);
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL ripple_latency: got %0d want 4", lat);
    end
    consume16();
  endtask

  task automatic test_carry_in();
    int lat; logic ok;
    run16(16'h1234, 16'h4321, 1'b1, lat, ok);
    tests_run++;
    if (s16 !== 17'h05556) begin
      tests_failed++;
      $display("FAIL cin_sum: got %h want 05556", s16);
    end
    tests_run++;
    if (lat !== 4) begin
      tests_failed++;
      $display("FAIL cin_latency: got %0d want 4", lat);
    end
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL cin_ready_busy: got ok=%b want 1 (ready_o=0, busy_o=1 during RUN)", ok);
    end
    consume16();
  endtask

  task automatic test_small_32();
    int lat;
    int exp_lat;
`ifdef CLA_SEQ_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = 8;
`endif
    @(negedge clk);
    a32 = 32'h3; b32 = 32'h4; cin32 = 1'b0; v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 0;
    while (vo32 !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (s32 !== 33'h7) begin
      tests_failed++;
      $display("FAIL small32_sum: got %h want 7", s32);
    end
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL small32_latency: got %0d want %0d", lat, exp_lat);
    end
    @(posedge clk); #1;
    tests_run++;
    if (ro32 !== 1'b1 || vo32 !== 1'b0) begin
      tests_failed++;
      $display("FAIL small32_return_idle: ready=%b valid=%b want 1 0", ro32, vo32);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic ok; logic held;
    @(negedge clk);
    rdy16 = 1'b0;
    run16(16'h8000, 16'h8000, 1'b0, lat, ok);
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (vo16 !== 1'b1 || s16 !== 17'h10000 || ro16 !== 1'b0) held = 1'b0;
      @(posedge clk); #1;
    end
    tests_run++;
    if (held !== 1'b1 || s16 !== 17'h10000) begin
      tests_failed++;
      $display("FAIL backpressure_hold: held=%b sum=%h want 1 10000", held, s16);
    end
    consume16();
    tests_run++;
    if (vo16 !== 1'b0 || ro16 !== 1'b1 || bo16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: valid=%b ready=%b busy=%b want 0 1 0", vo16, ro16, bo16);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic ok; int exp_lat;
`ifdef CLA_SEQ_EARLY_EXIT_EN
    exp_lat = 1;
`else
    exp_lat = 4;
`endif
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (ro16 !== 1'b1 || vo16 !== 1'b0 || bo16 !== 1'b0 || s16 !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: ready=%b valid=%b busy=%b sum=%h want 1 0 0 00000", ro16, vo16, bo16, s16);
    end
    @(negedge clk);
    rst = 1'b0;
    run16(16'h0001, 16'h0001, 1'b0, lat, ok);
    tests_run++;
    if (s16 !== 17'h00002 || lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL after_reset_add: sum=%h lat=%0d want 00002 %0d", s16, lat, exp_lat);
    end
    consume16();
  endtask

  task automatic test_operand_change();
    int lat;
    @(negedge clk);
    a16 = 16'h0F0F; b16 = 16'h1111; cin16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    lat = 0;
    while (vo16 !== 1'b1 && lat < 50) begin
      a16 = ~a16;
      b16 = b16 + 16'h1357;
      @(posedge clk); #1;
      lat++;
    end
    tests_run++;
    if (s16 !== 17'h02020) begin
      tests_failed++;
      $display("FAIL operand_change: got %h want 02020", s16);
    end
    consume16();
  endtask

  task automatic test_back_to_back();
    int cnt; logic seen_idle; logic [16:0] first_sum; int acc_cnt;
    @(negedge clk);
    rdy16 = 1'b1;
    a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0; v16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'hABCD; b16 = 16'h1234;
    cnt = 0; seen_idle = 1'b0; first_sum = '0; acc_cnt = -1;
    while (cnt < 50 && acc_cnt < 0) begin
      @(posedge clk); #1;
      cnt++;
      if (vo16 === 1'b1) first_sum = s16;
      if (ro16 === 1'b1) seen_idle = 1'b1;
      else if (seen_idle) acc_cnt = cnt;
    end
    v16 = 1'b0;
    tests_run++;
    if (first_sum !== 17'h08000) begin
      tests_failed++;
      $display("FAIL b2b_first_sum: got %h want 08000", first_sum);
    end
    tests_run++;
    if (acc_cnt !== 6) begin
      tests_failed++;
      $display("FAIL b2b_throughput: got %0d cycles want 6", acc_cnt);
    end
    cnt = 0;
    while (vo16 !== 1'b1 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    tests_run++;
    if (s16 !== 17'h0BE01 || cnt !== 4) begin
      tests_failed++;
      $display("FAIL b2b_second: sum=%h lat=%0d want 0BE01 4", s16, cnt);
    end
    consume16();
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; rdy16 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; rdy32 = 1'b1;
    test_reset();
    test_full_ripple();
    test_carry_in();
    test_small_32();
    test_backpressure();
    test_reset_mid_run();
    test_operand_change();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cla_serial_add_sequencer.md
# cla_serial_add_sequencer

Multi-cycle wide adder controller that sequences a single 4-bit carry-lookahead slice across a WIDTH-bit operand pair, one nibble per clock, with a registered carry between nibbles. It sits between an operand producer and a result consumer using valid/ready handshakes on both sides. It trades latency for area where a full-width lookahead tree is not justified.

## Interface
- WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 8.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  operands and carry-in are valid.
- ready_o  output  1  block can accept operands; high only in IDLE.
- number_1_i  input  WIDTH  operand A.
- number_2_i  input  WIDTH  operand B.
- carry_i_i  input  1  carry-in to bit 0.
- valid_o  output  1  sum_o is valid; held until consumed.
- ready_i  input  1  consumer accepts the result.
- sum_o  output  WIDTH+1  A + B + carry_i_i; MSB is the final carry-out.
- busy_o  output  1  high in RUN and DONE.

## Operation
- States: IDLE, RUN, DONE.
- Reset (async): state=IDLE, nibble counter=0, carry register=0, operand and sum registers=0. Output values during and after reset: ready_o=1, valid_o=0, busy_o=0, sum_o=0.
- IDLE: on valid_i & ready_o, the block latches number_1_i, number_2_i and carry_i_i into the carry register, clears the counter, and moves to RUN. valid_i without ready_o is ignored.
- RUN: each cycle the 4-bit slice adds nibble k of A and B plus the carry register.
  - Sum nibble k is written to sum bits [4k+3:4k].
  - The slice carry-out is written to the carry register.
  - k increments.
  - After nibble N-1 (N=WIDTH/4), the final carry is written to sum bit WIDTH and the state moves to DONE.
- DONE: valid_o=1 and sum_o holds stable. When valid_o & ready_i, the state moves to IDLE. A new operand cannot be accepted in the same cycle.
- Arithmetic is unsigned modulo 2^(WIDTH+1). There is no overflow flag.
- Input operands are ignored after capture. Changes on number_*_i during RUN have no effect.
- sum_o bits not yet computed in RUN read as 0, because the sum register is cleared on accept.

## Timing
- Accept edge = E0. RUN occupies cycles E0..E(N-1), and valid_o rises after edge EN.
- Latency from accept to valid_o: N cycles (8 for WIDTH=32).
- Throughput: one result per N+2 cycles when the consumer does not stall.
- Back-pressure: DONE is held indefinitely while ready_i=0, and sum_o is stable throughout.
- ready_i during IDLE or RUN has no effect.
- rst_i asserted in mid-RUN or mid-DONE aborts the operation immediately. The block returns to the reset values, and no partial result is presented.
- The counter is exactly clog2(N) bits and does not wrap. The terminal compare at k=N-1 triggers DONE.

## Configuration
- CLA_SEQ_EARLY_EXIT_EN defined:
  - In RUN, after nibble k is processed, the block tests three conditions: all remaining operand bits above nibble k are zero in both A and B, the new carry register is 0, and k < N-1.
  - If all three hold, it moves to DONE on the next edge. Remaining sum bits, including bit WIDTH, stay 0.
  - Latency becomes k+1 cycles, with a minimum of 1.
- CLA_SEQ_EARLY_EXIT_EN undefined: latency is always exactly N cycles and the early-exit logic is absent.
- sum_o is bit-identical in both builds.

## Test plan
- WIDTH=16, A=0xFFFF, B=0x0001, cin=0 -> sum_o=0x10000, valid_o after exactly 4 cycles (both builds: the carry ripples through every nibble).
- WIDTH=16, A=0x1234, B=0x4321, cin=1 -> sum_o=0x05556. Latency 4 cycles, ready_o=0 and busy_o=1 throughout.
- WIDTH=32, A=0x00000003, B=0x00000004, cin=0 -> sum_o=0x7. Latency 8 cycles without CLA_SEQ_EARLY_EXIT_EN, 1 cycle with it.
- Back-pressure: complete 0x8000+0x8000 (WIDTH=16) with ready_i=0 for 10 cycles -> valid_o stays 1 and sum_o stays 0x10000. It drops the cycle after ready_i=1, and ready_o returns to 1.
- Reset mid-RUN: assert rst_i at cycle 2 of a WIDTH=16 add -> ready_o=1, valid_o=0, sum_o=0 immediately. A following add of 0x0001+0x0001 returns 0x00002.
- Operand change during RUN: toggle number_1_i every cycle after accept -> sum_o equals the sum of the captured operands.
